// File: rtl/viterbi_decoder.sv
// ---------------------------------------------------------------------------
// viterbi_decoder
//   Hard-decision Viterbi decoder for the K=7, rate-1/2 (133/171) convolutional
//   code. Each enabled cycle performs one trellis step over all 64 states using
//   add-compare-select, and updates a register-exchange survivor memory. Path
//   metrics wrap modulo 2^PM_W and are never normalised. All comparisons use
//   the MSB of the modular difference. This is exact because the metric spread
//   stays small. Once TB_DEPTH symbols have been accepted, the oldest survivor
//   bit of the best state is emitted one cycle after each enabled step.
//
// Ports
//   Clk        in   clock, rising edge
//   reset      in   synchronous, active-high; restarts decoding at state 0
//   en         in   accept data_in/erase this cycle (one trellis step)
//   data_in    in   [1:0] coded pair {B,A}; A = 133 output, B = 171 output
//   erase      in   [1:0] per-bit erasure; an erased bit adds 0 to the metric
//   data_out   out  decoded bit (registered, holds between valid pulses)
//   valid_out  out  one-cycle pulse marking a new decoded bit
// ---------------------------------------------------------------------------
module viterbi_decoder #(
   parameter int TB_DEPTH = 36,
   parameter int PM_W     = 8
) (
   input  logic       Clk,
   input  logic       reset,
   input  logic       en,
   input  logic [1:0] data_in,
   input  logic [1:0] erase,
   output logic       data_out,
   output logic       valid_out
);

   localparam int NS     = 64;
   localparam int FILL_W = $clog2(TB_DEPTH + 1);
   localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(TB_DEPTH);

   logic [PM_W-1:0]     pm_q [NS];
   logic [PM_W-1:0]     pm_d [NS];
   logic [TB_DEPTH-1:0] sr_q [NS];
   logic [TB_DEPTH-1:0] sr_d [NS];
   logic [FILL_W-1:0]   fill_q, fill_d;
   logic                en_d1_q, en_d1_d;
   logic                data_out_q, data_out_d;
   logic                valid_out_q, valid_out_d;

   logic [PM_W-1:0]     cand0 [NS];
   logic [PM_W-1:0]     cand1 [NS];
   logic [PM_W-1:0]     acs_diff [NS];
   logic                sel [NS];

   logic [5:0]          best_idx;
   logic [PM_W-1:0]     best_diff;

   // Hamming distance between the branch's expected pair and the received
   // pair, with erased positions contributing nothing.
   function automatic logic [1:0] branch_metric(
      input logic [5:0] s,
      input logic       d,
      input logic [1:0] din,
      input logic [1:0] ers
   );
      logic a_exp;
      logic b_exp;
      logic ma;
      logic mb;
      a_exp = d ^ s[1] ^ s[2] ^ s[4] ^ s[5];
      b_exp = d ^ s[0] ^ s[1] ^ s[2] ^ s[5];
      ma    = (a_exp != din[0]) & ~ers[0];
      mb    = (b_exp != din[1]) & ~ers[1];
      return {1'b0, ma} + {1'b0, mb};
   endfunction

   // Add-compare-select for every next state n. Predecessors differ only in
   // their oldest bit. The upper predecessor wins only when it is strictly
   // better in the modular sense, so ties fall to the lower one.
   always_comb begin
      for (int n = 0; n < NS; n++) begin
         cand0[n]    = pm_q[{1'b0, 5'(n >> 1)}]
                       + PM_W'(branch_metric({1'b0, 5'(n >> 1)}, n[0], data_in, erase));
         cand1[n]    = pm_q[{1'b1, 5'(n >> 1)}]
                       + PM_W'(branch_metric({1'b1, 5'(n >> 1)}, n[0], data_in, erase));
         acs_diff[n] = cand0[n] - cand1[n];
         sel[n]      = ~acs_diff[n][PM_W-1] && (acs_diff[n] != '0);
      end
   end

   // Best-state search over the registered metrics. A later index replaces
   // the current best only when strictly smaller, so ties keep the lowest.
   always_comb begin
      best_idx  = '0;
      best_diff = '0;
      for (int i = 1; i < NS; i++) begin
         best_diff = pm_q[i] - pm_q[best_idx];
         if (best_diff[PM_W-1]) begin
            best_idx = 6'(i);
         end
      end
   end

   // Next-state logic. Metrics, survivors and fill are frozen while en is low.
   // The output stage reads the state left behind by the previous step.
   always_comb begin
      pm_d        = pm_q;
      sr_d        = sr_q;
      fill_d      = fill_q;
      en_d1_d     = en;
      data_out_d  = data_out_q;
      valid_out_d = 1'b0;
      if (en) begin
         for (int n = 0; n < NS; n++) begin
            pm_d[n] = sel[n] ? cand1[n] : cand0[n];
            sr_d[n] = {sr_q[{sel[n], 5'(n >> 1)}][TB_DEPTH-2:0], n[0]};
         end
         if (fill_q != FILL_MAX) begin
            fill_d = fill_q + FILL_W'(1);
         end
      end
      if (en_d1_q && (fill_q == FILL_MAX)) begin
         valid_out_d = 1'b1;
         data_out_d  = sr_q[best_idx][TB_DEPTH-1];
      end
   end

   // State registers. Reset biases every state but 0 so that decoding starts
   // from the all-zero encoder state.
   always_ff @(posedge Clk) begin
      if (reset) begin
         for (int i = 0; i < NS; i++) begin
            pm_q[i] <= (i == 0) ? '0 : PM_W'(16);
            sr_q[i] <= '0;
         end
         fill_q      <= '0;
         en_d1_q     <= 1'b0;
         data_out_q  <= 1'b0;
         valid_out_q <= 1'b0;
      end else begin
         pm_q        <= pm_d;
         sr_q        <= sr_d;
         fill_q      <= fill_d;
         en_d1_q     <= en_d1_d;
         data_out_q  <= data_out_d;
         valid_out_q <= valid_out_d;
      end
   end

   assign data_out  = data_out_q;
   assign valid_out = valid_out_q;

endmodule
